fsm_seq_monitor: RTL and testbench

Passive checker for the 4-state Mealy sequence FSM (input in, output out). It watches the FSM's input/output pair every sampled cycle and steps its own golden copy of the transition/output table. It flags any cycle where the observed output differs from the golden output, and logs the first divergence. The monitor sits beside the FSM in the test/trojan-detection harness and is the reading end of the FSM's output stream.

---
 rtl/fsm_seq_pkg.sv | 42 ++++
 rtl/fsm_seq_monitor_golden_step.sv | 22 ++
 rtl/fsm_seq_monitor.sv | 113 +++++++++++
 tb/tb_fsm_seq_monitor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_seq_pkg.sv
// fsm_seq_pkg
// Shared definitions for the 4-state Mealy sequence FSM and its monitor:
// state encodings and the golden transition/output table as functions.
// Shared with the FSM's own testbench.
package fsm_seq_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    // Golden next state for (state, input).
    function automatic state_t golden_next(state_t s, logic in_bit);
        state_t r;
        r = S0;
        case (s)
            S0: r = in_bit ? S3 : S1;
            S1: r = in_bit ? S2 : S0;
            S2: r = in_bit ? S0 : S3;
            S3: r = in_bit ? S1 : S3;
            default: r = S0;
        endcase
        return r;
    endfunction

    // Golden Mealy output for (state, input).
    function automatic logic golden_out(state_t s, logic in_bit);
        logic r;
        r = 1'b0;
        case (s)
            S0: r = 1'b1;
            S1: r = 1'b1;
            S2: r = in_bit;
            S3: r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fsm_seq_monitor_golden_step.sv
// fsm_golden_step
// Purely combinational single step of the golden FSM table.
// Ports:
//   state_cur  in   current golden state
//   bit_in     in   FSM input
//   state_nxt  out  golden next state
//   bit_out    out  golden Mealy output
module fsm_golden_step
    import fsm_seq_pkg::*;
(
    input  logic [1:0] state_cur,
    input  logic       bit_in,
    output logic [1:0] state_nxt,
    output logic       bit_out
);

    always_comb begin
        state_nxt = golden_next(state_t'(state_cur), bit_in);
        bit_out   = golden_out(state_t'(state_cur), bit_in);
    end

endmodule

// File: rtl/fsm_seq_monitor.sv
// fsm_seq_monitor
// Passive checker for the 4-state Mealy sequence FSM. Tracks a golden copy
// of the FSM on valid samples and flags/logs observed output divergence.
// Ports:
//   clk, reset_n (sync, active-low), clr (sync soft clear)
//   smp_valid, dut_in, dut_out      observed FSM cycle
//   exp_out                          golden output (combinational)
//   gstate                           golden state register
//   mismatch                         one-cycle pulse after a bad sample
//   alarm                            sticky, mismatch_cnt reached ALARM_TH
//   mismatch_cnt, sample_cnt         saturating counters
//   first_err_idx/state/vld          capture of the first divergence
module fsm_seq_monitor
    import fsm_seq_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int ALARM_TH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             smp_valid,
    input  logic             dut_in,
    input  logic             dut_out,
    output logic             exp_out,
    output logic [1:0]       gstate,
    output logic             mismatch,
    output logic             alarm,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [1:0]       first_err_state,
    output logic             first_err_vld
);

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TH_V = CNT_W'(ALARM_TH);

    state_t           gstate_q, gstate_d;
    logic [1:0]       step_nxt;
    logic             miss;
    logic             mismatch_d, alarm_d, fe_vld_d;
    logic [CNT_W-1:0] mcnt_d, scnt_d, fe_idx_d;
    state_t           fe_state_d;

    fsm_golden_step u_step (
        .state_cur (gstate_q),
        .bit_in    (dut_in),
        .state_nxt (step_nxt),
        .bit_out   (exp_out)
    );

    assign gstate = gstate_q;
    assign miss   = (dut_out != exp_out);

    always_comb begin
        gstate_d   = gstate_q;
        scnt_d     = sample_cnt;
        mcnt_d     = mismatch_cnt;
        mismatch_d = 1'b0;
        fe_idx_d   = first_err_idx;
        fe_state_d = state_t'(first_err_state);
        fe_vld_d   = first_err_vld;
        alarm_d    = alarm;
        if (clr) begin
            // Clear drops any sample presented in the same cycle.
            gstate_d   = S0;
            scnt_d     = '0;
            mcnt_d     = '0;
            fe_idx_d   = '0;
            fe_state_d = S0;
            fe_vld_d   = 1'b0;
            alarm_d    = 1'b0;
        end else if (smp_valid) begin
            // Golden path never follows the DUT, even after a mismatch.
            gstate_d = state_t'(step_nxt);
            scnt_d   = (sample_cnt == '1) ? sample_cnt : sample_cnt + ONE;
            if (miss) begin
                mismatch_d = 1'b1;
                mcnt_d     = (mismatch_cnt == '1) ? mismatch_cnt : mismatch_cnt + ONE;
                if (!first_err_vld) begin
                    fe_idx_d   = sample_cnt;
                    fe_state_d = gstate_q;
                    fe_vld_d   = 1'b1;
                end
            end
            alarm_d = alarm | (mcnt_d >= TH_V);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gstate_q        <= S0;
            sample_cnt      <= '0;
            mismatch_cnt    <= '0;
            mismatch        <= 1'b0;
            alarm           <= 1'b0;
            first_err_idx   <= '0;
            first_err_state <= S0;
            first_err_vld   <= 1'b0;
        end else begin
            gstate_q        <= gstate_d;
            sample_cnt      <= scnt_d;
            mismatch_cnt    <= mcnt_d;
            mismatch        <= mismatch_d;
            alarm           <= alarm_d;
            first_err_idx   <= fe_idx_d;
            first_err_state <= fe_state_d;
            first_err_vld   <= fe_vld_d;
        end
    end

endmodule

// File: tb/tb_fsm_seq_monitor.sv
// tb_fsm_seq_monitor
// Random + directed bench for fsm_seq_monitor. Two instances (CNT_W=8 and
// CNT_W=4) see identical stimulus and are compared against a table-driven
// reference model every cycle.
module tb_fsm_seq_monitor;

    logic       clk = 1'b0;
    logic       reset_n, clr, smp_valid, dut_in, dut_out;

    logic       exp_out_a, mismatch_a, alarm_a, fe_vld_a;
    logic [1:0] gstate_a, fe_state_a;
    logic [7:0] mcnt_a, scnt_a, fe_idx_a;

    logic       exp_out_b, mismatch_b, alarm_b, fe_vld_b;
    logic [1:0] gstate_b, fe_state_b;
    logic [3:0] mcnt_b, scnt_b, fe_idx_b;

    always #5 clk = ~clk;

    fsm_seq_monitor #(.CNT_W(8), .ALARM_TH(2)) dut (
        .clk(clk), .reset_n(reset_n), .clr(clr), .smp_valid(smp_valid),
        .dut_in(dut_in), .dut_out(dut_out), .exp_out(exp_out_a),
        .gstate(gstate_a), .mismatch(mismatch_a), .alarm(alarm_a),
        .mismatch_cnt(mcnt_a), .sample_cnt(scnt_a),
        .first_err_idx(fe_idx_a), .first_err_state(fe_state_a),
        .first_err_vld(fe_vld_a)
    );

    fsm_seq_monitor #(.CNT_W(4), .ALARM_TH(2)) dut4 (
        .clk(clk), .reset_n(reset_n), .clr(clr), .smp_valid(smp_valid),
        .dut_in(dut_in), .dut_out(dut_out), .exp_out(exp_out_b),
        .gstate(gstate_b), .mismatch(mismatch_b), .alarm(alarm_b),
        .mismatch_cnt(mcnt_b), .sample_cnt(scnt_b),
        .first_err_idx(fe_idx_b), .first_err_state(fe_state_b),
        .first_err_vld(fe_vld_b)
    );

    // Reference table, indexed [state][in].
    int nxt_tab [4][2] = '{'{1, 3}, '{0, 2}, '{3, 0}, '{3, 1}};
    int out_tab [4][2] = '{'{1, 1}, '{1, 1}, '{0, 1}, '{0, 0}};
    int maxv    [2]    = '{255, 15};

    typedef struct {
        int gs, sc, mc, mm, al, fidx, fst, fvld;
    } model_t;

    model_t m [2];
    int     n_vec = 0;
    int     n_err = 0;
    bit     chk_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: updated from the inputs seen at each rising edge.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            model_t t;
            int     e;
            t = m[k];
            if (!reset_n || clr) begin
                t = '{0, 0, 0, 0, 0, 0, 0, 0};
            end else if (smp_valid) begin
                e = out_tab[t.gs][int'(dut_in)];
                t.mm = (int'(dut_out) != e) ? 1 : 0;
                if (t.mm == 1 && t.fvld == 0) begin
                    t.fidx = t.sc;
                    t.fst  = t.gs;
                    t.fvld = 1;
                end
                t.gs = nxt_tab[t.gs][int'(dut_in)];
                if (t.sc < maxv[k]) t.sc = t.sc + 1;
                if (t.mm == 1 && t.mc < maxv[k]) t.mc = t.mc + 1;
                if (t.mc >= 2) t.al = 1;
            end else begin
                t.mm = 0;
            end
            m[k] <= t;
        end
    end

    // Compare process on the falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("a.exp_out", int'(exp_out_a), out_tab[m[0].gs][int'(dut_in)]);
            chk("a.gstate", int'(gstate_a), m[0].gs);
            chk("a.mismatch", int'(mismatch_a), m[0].mm);
            chk("a.alarm", int'(alarm_a), m[0].al);
            chk("a.mismatch_cnt", int'(mcnt_a), m[0].mc);
            chk("a.sample_cnt", int'(scnt_a), m[0].sc);
            chk("a.first_err_idx", int'(fe_idx_a), m[0].fidx);
            chk("a.first_err_state", int'(fe_state_a), m[0].fst);
            chk("a.first_err_vld", int'(fe_vld_a), m[0].fvld);
            chk("b.exp_out", int'(exp_out_b), out_tab[m[1].gs][int'(dut_in)]);
            chk("b.gstate", int'(gstate_b), m[1].gs);
            chk("b.mismatch", int'(mismatch_b), m[1].mm);
            chk("b.alarm", int'(alarm_b), m[1].al);
            chk("b.mismatch_cnt", int'(mcnt_b), m[1].mc);
            chk("b.sample_cnt", int'(scnt_b), m[1].sc);
            chk("b.first_err_idx", int'(fe_idx_b), m[1].fidx);
            chk("b.first_err_state", int'(fe_state_b), m[1].fst);
            chk("b.first_err_vld", int'(fe_vld_b), m[1].fvld);
        end
    end

    // Present inputs, then wait past the next rising edge.
    task automatic apply(input bit v, input bit i, input bit o);
        smp_valid = v;
        dut_in    = i;
        dut_out   = o;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          seq_in  [5] = '{0, 1, 0, 1, 0};
        int          seq_out [5] = '{1, 1, 0, 0, 1};
        int          seq_gs  [5] = '{1, 2, 3, 1, 0};
        bit          i, o;
        int unsigned r;

        m[0] = '{0, 0, 0, 0, 0, 0, 0, 0};
        m[1] = '{0, 0, 0, 0, 0, 0, 0, 0};
        reset_n = 1'b0; clr = 1'b0;
        apply(1'b1, 1'b0, 1'b0);
        chk_on = 1'b1;
        chk("reset.sample_cnt", int'(scnt_a), 0);
        chk("reset.gstate", int'(gstate_a), 0);
        reset_n = 1'b1;

        // Matching stream from S0.
        for (int k = 0; k < 5; k++) begin
            apply(1'b1, bit'(seq_in[k]), bit'(seq_out[k]));
            chk("seq.gstate", int'(gstate_a), seq_gs[k]);
        end
        chk("seq.sample_cnt", int'(scnt_a), 5);
        chk("seq.mismatch_cnt", int'(mcnt_a), 0);
        chk("seq.alarm", int'(alarm_a), 0);

        // First divergence: S0, in=1 expects 1, observe 0 (sample index 5).
        apply(1'b1, 1'b1, 1'b0);
        chk("div.mismatch", int'(mismatch_a), 1);
        chk("div.first_err_idx", int'(fe_idx_a), 5);
        chk("div.first_err_state", int'(fe_state_a), 0);
        chk("div.first_err_vld", int'(fe_vld_a), 1);
        chk("div.alarm", int'(alarm_a), 0);
        chk("div.gstate", int'(gstate_a), 3);
        // Second divergence: S3, in=0 expects 0, observe 1.
        apply(1'b1, 1'b0, 1'b1);
        chk("div2.alarm", int'(alarm_a), 1);
        chk("div2.mismatch_cnt", int'(mcnt_a), 2);
        chk("div2.first_err_idx", int'(fe_idx_a), 5);
        apply(1'b1, 1'b0, 1'b0);
        chk("div3.mismatch", int'(mismatch_a), 0);
        chk("div3.alarm", int'(alarm_a), 1);

        // Idle with garbage outputs: nothing moves.
        for (int k = 0; k < 3; k++) apply(1'b0, bit'($urandom_range(1)), bit'($urandom_range(1)));
        chk("idle.sample_cnt", int'(scnt_a), 8);
        chk("idle.gstate", int'(gstate_a), 3);
        chk("idle.mismatch", int'(mismatch_a), 0);

        // Clear with a mismatching sample in the same cycle.
        clr = 1'b1;
        apply(1'b1, 1'b0, 1'b1);
        clr = 1'b0;
        chk("clr.sample_cnt", int'(scnt_a), 0);
        chk("clr.mismatch", int'(mismatch_a), 0);
        chk("clr.alarm", int'(alarm_a), 0);
        chk("clr.first_err_vld", int'(fe_vld_a), 0);

        // Random phase.
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(99);
            clr = (r < 3);
            reset_n = !(k == 200);
            i = bit'($urandom_range(1));
            o = bit'(out_tab[m[0].gs][int'(i)]) ^ ($urandom_range(7) == 0);
            apply($urandom_range(3) != 0, i, o);
            if (k == 200) begin
                chk("midreset.sample_cnt", int'(scnt_a), 0);
                chk("midreset.alarm", int'(alarm_a), 0);
            end
        end
        clr = 1'b0; reset_n = 1'b1;

        // Saturation: 20 mismatching samples after a clear.
        clr = 1'b1;
        apply(1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        for (int k = 0; k < 20; k++) begin
            i = bit'($urandom_range(1));
            apply(1'b1, i, !bit'(out_tab[m[1].gs][int'(i)]));
        end
        chk("sat.sample_cnt", int'(scnt_b), 15);
        chk("sat.mismatch_cnt", int'(mcnt_b), 15);
        chk("sat.first_err_idx", int'(fe_idx_b), 0);
        chk("sat.wide_sample_cnt", int'(scnt_a), 20);

        // Drive past all-ones so the first capture lands at saturation.
        clr = 1'b1;
        apply(1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        for (int k = 0; k < 17; k++) begin
            i = bit'($urandom_range(1));
            o = bit'(out_tab[m[1].gs][int'(i)]);
            apply(1'b1, i, (k == 16) ? !o : o);
        end
        chk("sat.first_err_idx_ones", int'(fe_idx_b), 15);

        @(negedge clk);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
